mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (lw/sw).
- Sequences each access with a fixed-latency FSM.
- Drives per-port ready and stall so the pipeline freezes the requester that is waiting.
- Sits between the pipeline stages and the memory macro, beside the control unit.

Parameters:
- MEM_LAT, 2: cycles from the mem_en issue cycle to the cycle mem_rdata is valid. Legal range 1..15.
- MAX_D_BURST, 4: consecutive data grants allowed while if_req is pending before IF is forced a grant. Legal range 1..15.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request. Held high until if_ready.
- if_addr  in  32  fetch byte address. Stable while if_req is high.
- if_rdata  out  32  fetched instruction. Valid only while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request. Held high until d_ready.
- d_we  in  1  1=sw, 0=lw. Stable while d_req is high.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data. Valid only while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- stall_if  out  1  if_req & ~if_ready.
- stall_mem  out  1  d_req & ~d_ready.
- mem_en  out  1  memory access strobe. One cycle per transaction.
- mem_we  out  1  write strobe. Asserted only together with mem_en.
- mem_addr  out  32  memory address. Held for the whole transaction.
- mem_wdata  out  32  memory write data. Held for the whole transaction.
- mem_rdata  in  32  memory read data.
- arb_busy  out  1  1 when state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. A registered owner bit selects the port: 0=IF, 1=DATA.
- Reset (asynchronous, any state):
  - state=IDLE, owner=0, lat_cnt=0, d_streak=0.
  - mem_en, mem_we, mem_addr, mem_wdata all 0.
  - if_ready, d_ready, stall_if, stall_mem all 0.
  - An in-flight memory response is discarded; no ready is produced for it.
- IDLE: requests are sampled at the clock edge.
  - Both requests high: DATA wins, because MEM holds the older instruction.
  - Exception: if d_streak==MAX_D_BURST, IF wins.
  - Only one request high: that port wins.
  - No request: stay IDLE.
  - On a grant: latch the address (and, for DATA, d_we and d_wdata) into the mem_* registers, set owner, go to ISSUE.
- Streak counter:
  - A DATA grant made while if_req=1 increments d_streak, saturating at MAX_D_BURST.
  - Any IF grant clears d_streak.
  - A DATA grant made with if_req=0 clears d_streak.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=1 for a store.
  - lat_cnt loads MEM_LAT-1.
  - Next state is DONE if MEM_LAT==1, otherwise WAIT.
- WAIT:
  - mem_en=0 and mem_we=0.
  - lat_cnt decrements each cycle; go to DONE when lat_cnt reaches 0.
  - mem_addr and mem_wdata stay held.
- DONE (1 cycle):
  - The owner's ready=1.
  - Its rdata is driven combinationally from mem_rdata. For stores, rdata is don't-care.
  - Next state is always IDLE, so one bubble follows each transaction.
  - Requests are not sampled in DONE. This prevents regranting the requester whose req is still high during its ready cycle.
- Latency: a request sampled at the edge ending cycle T gives mem_en in T+1 and ready in T+1+MEM_LAT. The next grant issues no earlier than T+3+MEM_LAT.
- The non-owner's ready stays 0 throughout a transaction. A request arriving mid-transaction waits and is arbitrated at the next IDLE.
- Stores and loads take identical time.
- rdata outputs are 0 when their ready is 0.
- Protocol violation (requester drops req before its ready): the transaction still completes and the ready still pulses. The bench flags the violation; the RTL does not.
- The 32-bit address is passed unchanged. No alignment check.

Test Plan:
- MEM_LAT=2, reset, if_req=1 with if_addr=0x00000040 from cycle 0 -> mem_en=1 and mem_addr=0x40 in cycle 1; if_ready=1 with if_rdata=mem_rdata in cycle 3; stall_if=1 in cycles 0-2.
- if_req and d_req both rise in cycle 0, lw with d_addr=0x100 -> data issues in cycle 1 with mem_we=0; d_ready in cycle 3; IDLE in cycle 4; fetch issues in cycle 5; if_ready in cycle 7.
- sw with d_addr=0x200 and d_wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle with mem_en; mem_wdata held until DONE; d_ready after MEM_LAT+1 cycles.
- if_req held high, d_req reasserted immediately after each d_ready, MAX_D_BURST=4 -> grant order D,D,D,D,I,D…; d_streak returns to 0 after the IF grant.
- rst asserted in the WAIT cycle of a fetch -> all outputs 0 immediately (asynchronous); no if_ready; after release, a re-request completes with normal latency.
- MEM_LAT=1 sweep, and MEM_LAT=5 -> ready exactly MEM_LAT+1 cycles after sampling; arb_busy high from ISSUE through DONE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and memory-macro signals
// shared by the fetch and data ports of the memory arbiter.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    // Arbiter side: takes requests and memory read data, drives everything else.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata, arb_busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata, arb_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the MEM stage, sequencing each access through a fixed-latency FSM.
module mem_port_arbiter #(
    parameter int MEM_LAT     = 2,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_BURST);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  d_streak_q, d_streak_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        grant_d;
    logic        done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt_q  <= 4'd0;
            d_streak_q <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            lat_cnt_q  <= lat_cnt_d;
            d_streak_q <= d_streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // DATA has priority (older instruction) unless it has starved a waiting fetch.
    assign grant_d = bus.d_req && (!bus.if_req || (d_streak_q != MAX_STREAK));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        lat_cnt_d  = lat_cnt_q;
        d_streak_d = d_streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d = 1'b1;
                    we_d    = bus.d_we;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    state_d = ISSUE;
                    if (!bus.if_req)
                        d_streak_d = 4'd0;
                    else if (d_streak_q != MAX_STREAK)
                        d_streak_d = d_streak_q + 4'd1;
                end else if (bus.if_req) begin
                    owner_d    = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = bus.if_addr;
                    d_streak_d = 4'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q <= 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                // Requests are ignored here so the finishing port is not regranted.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done          = (state_q == DONE);
    assign bus.if_ready  = done && !owner_q;
    assign bus.d_ready   = done && owner_q;
    assign bus.if_rdata  = bus.if_ready ? bus.mem_rdata : 32'd0;
    assign bus.d_rdata   = bus.d_ready  ? bus.mem_rdata : 32'd0;
    assign bus.stall_if  = bus.if_req && !bus.if_ready && !rst;
    assign bus.stall_mem = bus.d_req  && !bus.d_ready  && !rst;
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances cover MEM_LAT = 2, 1, 5.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if b2 ();
    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b5 ();

    mem_port_arbiter #(.MEM_LAT(2), .MAX_D_BURST(4)) u_l2 (.clk(clk), .rst(rst), .bus(b2));
    mem_port_arbiter #(.MEM_LAT(1), .MAX_D_BURST(4)) u_l1 (.clk(clk), .rst(rst), .bus(b1));
    mem_port_arbiter #(.MEM_LAT(5), .MAX_D_BURST(4)) u_l5 (.clk(clk), .rst(rst), .bus(b5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0; b2.mem_rdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.mem_rdata = 0;
        b5.if_req = 0; b5.if_addr = 0; b5.d_req = 0; b5.d_we = 0; b5.d_addr = 0; b5.d_wdata = 0; b5.mem_rdata = 0;
        tick();
        tick();

        // Reset state, with a fetch already requested
        b2.if_req = 1'b1; b2.if_addr = 32'h0000_0040;
        #1;
        chk1("rst_mem_en", b2.mem_en, 1'b0);
        chk1("rst_busy", b2.arb_busy, 1'b0);
        chk1("rst_stall_if", b2.stall_if, 1'b0);
        chk1("rst_if_ready", b2.if_ready, 1'b0);
        chk32("rst_mem_addr", b2.mem_addr, 32'h0);

        // Single fetch, MEM_LAT=2
        tick();
        rst = 1'b0;
        #1;
        chk1("f_c0_stall", b2.stall_if, 1'b1);
        chk1("f_c0_en", b2.mem_en, 1'b0);
        tick();
        chk1("f_c1_en", b2.mem_en, 1'b1);
        chk32("f_c1_addr", b2.mem_addr, 32'h40);
        chk1("f_c1_busy", b2.arb_busy, 1'b1);
        chk1("f_c1_stall", b2.stall_if, 1'b1);
        b2.mem_rdata = 32'h1234_5678;
        tick();
        chk1("f_c2_en", b2.mem_en, 1'b0);
        chk1("f_c2_stall", b2.stall_if, 1'b1);
        chk32("f_c2_rdata0", b2.if_rdata, 32'h0);
        tick();
        chk1("f_c3_ready", b2.if_ready, 1'b1);
        chk32("f_c3_rdata", b2.if_rdata, 32'h1234_5678);
        chk1("f_c3_stall", b2.stall_if, 1'b0);
        b2.if_req = 1'b0;
        tick();
        chk1("f_c4_busy", b2.arb_busy, 1'b0);
        chk1("f_c4_ready", b2.if_ready, 1'b0);

        // Simultaneous lw and fetch: data first, fetch after the bubble
        b2.if_req = 1'b1; b2.if_addr = 32'h80;
        b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h100;
        b2.mem_rdata = 32'hCAFE_0001;
        tick();
        chk1("b_c1_en", b2.mem_en, 1'b1);
        chk32("b_c1_addr", b2.mem_addr, 32'h100);
        chk1("b_c1_we", b2.mem_we, 1'b0);
        chk1("b_c1_stall_mem", b2.stall_mem, 1'b1);
        tick();
        tick();
        chk1("b_c3_d_ready", b2.d_ready, 1'b1);
        chk32("b_c3_d_rdata", b2.d_rdata, 32'hCAFE_0001);
        chk1("b_c3_if_ready", b2.if_ready, 1'b0);
        chk32("b_c3_if_rdata", b2.if_rdata, 32'h0);
        chk1("b_c3_stall_if", b2.stall_if, 1'b1);
        chk1("b_c3_stall_mem", b2.stall_mem, 1'b0);
        b2.d_req = 1'b0;
        tick();
        chk1("b_c4_busy", b2.arb_busy, 1'b0);
        tick();
        chk1("b_c5_en", b2.mem_en, 1'b1);
        chk32("b_c5_addr", b2.mem_addr, 32'h80);
        b2.mem_rdata = 32'hCAFE_0002;
        tick();
        tick();
        chk1("b_c7_if_ready", b2.if_ready, 1'b1);
        chk32("b_c7_if_rdata", b2.if_rdata, 32'hCAFE_0002);
        b2.if_req = 1'b0;
        tick();

        // Store: write strobe for one cycle, write data held to completion
        b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 32'h200; b2.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk1("s_c1_en", b2.mem_en, 1'b1);
        chk1("s_c1_we", b2.mem_we, 1'b1);
        chk32("s_c1_wdata", b2.mem_wdata, 32'hDEAD_BEEF);
        chk32("s_c1_addr", b2.mem_addr, 32'h200);
        tick();
        chk1("s_c2_en", b2.mem_en, 1'b0);
        chk1("s_c2_we", b2.mem_we, 1'b0);
        chk32("s_c2_wdata", b2.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk1("s_c3_d_ready", b2.d_ready, 1'b1);
        chk32("s_c3_wdata", b2.mem_wdata, 32'hDEAD_BEEF);
        chk32("s_c3_addr", b2.mem_addr, 32'h200);
        b2.d_req = 1'b0; b2.d_we = 1'b0;
        tick();
        chk1("s_c4_busy", b2.arb_busy, 1'b0);

        // Streak limit: grant order D,D,D,D,I,D
        b2.if_req = 1'b1; b2.if_addr = 32'h300;
        b2.d_req = 1'b1; b2.d_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1($sformatf("st%0d_en", k), b2.mem_en, 1'b1);
            chk32($sformatf("st%0d_addr", k), b2.mem_addr, (k == 4) ? 32'h300 : 32'h400);
            if (k == 3) chk32("st3_streak", 32'(u_l2.d_streak_q), 32'd4);
            if (k == 4) chk32("st4_streak", 32'(u_l2.d_streak_q), 32'd0);
            tick();
            tick();
            chk1($sformatf("st%0d_d_ready", k), b2.d_ready, (k != 4));
            chk1($sformatf("st%0d_if_ready", k), b2.if_ready, (k == 4));
            tick();
        end
        b2.if_req = 1'b0; b2.d_req = 1'b0;
        tick();
        chk1("st_end_busy", b2.arb_busy, 1'b0);

        // Asynchronous reset during the WAIT cycle of a fetch
        b2.if_req = 1'b1; b2.if_addr = 32'h500;
        tick();
        tick();
        chk1("r_c2_busy", b2.arb_busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("r_async_busy", b2.arb_busy, 1'b0);
        chk1("r_async_stall", b2.stall_if, 1'b0);
        chk32("r_async_addr", b2.mem_addr, 32'h0);
        chk32("r_async_wdata", b2.mem_wdata, 32'h0);
        tick();
        chk1("r_no_ready", b2.if_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk1("r_c1_en", b2.mem_en, 1'b1);
        chk32("r_c1_addr", b2.mem_addr, 32'h500);
        tick();
        tick();
        chk1("r_c3_ready", b2.if_ready, 1'b1);
        b2.if_req = 1'b0;
        tick();

        // MEM_LAT=1 store and MEM_LAT=5 fetch side by side
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h600; b1.d_wdata = 32'h0BAD_F00D;
        b5.if_req = 1'b1; b5.if_addr = 32'h700; b5.mem_rdata = 32'h55AA_55AA;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk1($sformatf("l1_c%0d_en", c), b1.mem_en, (c == 1));
            chk1($sformatf("l1_c%0d_we", c), b1.mem_we, (c == 1));
            chk1($sformatf("l1_c%0d_ready", c), b1.d_ready, (c == 2));
            chk1($sformatf("l1_c%0d_busy", c), b1.arb_busy, (c <= 2));
            chk1($sformatf("l5_c%0d_en", c), b5.mem_en, (c == 1));
            chk1($sformatf("l5_c%0d_ready", c), b5.if_ready, (c == 6));
            chk1($sformatf("l5_c%0d_busy", c), b5.arb_busy, (c <= 6));
            chk32($sformatf("l5_c%0d_rdata", c), b5.if_rdata, (c == 6) ? 32'h55AA_55AA : 32'h0);
            if (c == 2) b1.d_req = 1'b0;
            if (c == 6) b5.if_req = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
